// File: rtl/piso_pkg.sv
// Shared types for the parallel-in/serial-out stage.
// State encoding and counter-width helper.
package piso_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  localparam int WIDTH_DEF = 4;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry holding buffer with bypass for piso_serializer.
// Ports: clk, rst, wr_en/wr_data in, rd_en in, full/rd_data out.
module piso_hold_reg
  import piso_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (rd_en) full_d = 1'b0;
    if (wr_en) begin
      data_d = wr_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  // Empty buffer passes the incoming word straight through.
  assign rd_data = full_q ? data_q : wr_data;
  assign full    = full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage, one bit per clk, gapless word stream.
// Ports: in_valid/in_ready/in_data in; serial_out/valid, frame_start, busy out.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             serial_out_q, serial_out_d;
  logic             serial_valid_q, serial_valid_d;
  logic             frame_start_q, frame_start_d;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             accept;
  logic             hold_wr;
  logic             hold_rd;
  logic             load;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign in_ready = ~hold_full & ~rst;
  assign accept   = in_valid & in_ready;

  // Mid-word accepts park in the hold register.
  assign hold_wr = accept & (state_q == SHIFT) & (bit_cnt_q < LAST);
  assign hold_rd = (state_q == SHIFT) & (bit_cnt_q == LAST) & hold_full;

  piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (hold_wr),
    .wr_data (in_data),
    .rd_en   (hold_rd),
    .full    (hold_full),
    .rd_data (hold_data)
  );

  always_comb begin
    state_d        = state_q;
    shift_reg_d    = shift_reg_q;
    bit_cnt_d      = bit_cnt_q;
    serial_out_d   = serial_out_q;
    serial_valid_d = serial_valid_q;
    frame_start_d  = frame_start_q;
    load           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) load = 1'b1;
      end
      SHIFT: begin
        if (bit_cnt_q < LAST) begin
          serial_out_d  = first_bit(shift_reg_q);
          shift_reg_d   = shift_word(shift_reg_q);
          bit_cnt_d     = bit_cnt_q + CW'(1);
          frame_start_d = 1'b0;
        end else if (hold_full || accept) begin
          load = 1'b1;
        end else begin
          state_d        = IDLE;
          serial_out_d   = 1'b0;
          serial_valid_d = 1'b0;
          frame_start_d  = 1'b0;
          bit_cnt_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // hold_data is either the held word or in_data via bypass.
    if (load) begin
      state_d        = SHIFT;
      serial_out_d   = first_bit(hold_data);
      shift_reg_d    = shift_word(hold_data);
      serial_valid_d = 1'b1;
      frame_start_d  = 1'b1;
      bit_cnt_d      = CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      shift_reg_q    <= '0;
      bit_cnt_q      <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_reg_q    <= shift_reg_d;
      bit_cnt_q      <= bit_cnt_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign frame_start  = frame_start_q;
  assign busy         = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer.
// MSB-first and LSB-first instances plus a behavioural sipo.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       serial_out;
  logic       serial_valid;
  logic       frame_start;
  logic       busy;

  logic       l_valid = 1'b0;
  logic       l_ready;
  logic [3:0] l_data = '0;
  logic       l_out;
  logic       l_sv;
  logic       l_fs;
  logic       l_busy;

  logic [3:0] sipo_q = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) sipo_q <= {sipo_q[2:0], serial_out};

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .frame_start  (frame_start),
    .busy         (busy)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (l_valid),
    .in_ready     (l_ready),
    .in_data      (l_data),
    .serial_out   (l_out),
    .serial_valid (l_sv),
    .frame_start  (l_fs),
    .busy         (l_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic rdy);
    chk({tag, ".so"}, 32'(serial_out), 0);
    chk({tag, ".sv"}, 32'(serial_valid), 0);
    chk({tag, ".fs"}, 32'(frame_start), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".rdy"}, 32'(in_ready), 32'(rdy));
  endtask

  // Bits are listed MSB-side first: bits[n-1] is the first on the wire.
  task automatic chk_bits(input string tag, input logic [7:0] bits,
                          input logic [7:0] fsm, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s.so%0d", tag, i), 32'(serial_out), 32'(bits[n-1-i]));
      chk($sformatf("%s.sv%0d", tag, i), 32'(serial_valid), 1);
      chk($sformatf("%s.fs%0d", tag, i), 32'(frame_start), 32'(fsm[n-1-i]));
    end
  endtask

  task automatic send_one(input logic [3:0] w);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    // Power-on reset
    #2;
    chk_idle("rst0", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle("rel0", 1'b1);

    // Single word 1011
    send_one(4'b1011);
    chk_bits("w1011", 8'b1011, 8'b1000, 4);
    @(negedge clk);
    chk_idle("w1011.end", 1'b1);

    // Back-to-back A then 5
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'hA;
    @(posedge clk);
    #1 in_data = 4'h5;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      logic [7:0] f;
      b = 8'hA5;
      f = 8'b1000_1000;
      @(negedge clk);
      chk($sformatf("b2b.so%0d", i), 32'(serial_out), 32'(b[7-i]));
      chk($sformatf("b2b.sv%0d", i), 32'(serial_valid), 1);
      chk($sformatf("b2b.fs%0d", i), 32'(frame_start), 32'(f[7-i]));
      if (i >= 1 && i <= 3)
        chk($sformatf("b2b.rdy%0d", i), 32'(in_ready), 0);
      if (i == 4)
        chk("b2b.rdy4", 32'(in_ready), 1);
      if (i == 1) in_valid = 1'b0;
    end
    @(negedge clk);
    chk_idle("b2b.end", 1'b1);

    // Chain into sipo
    send_one(4'b0110);
    chk_bits("sipo", 8'b0110, 8'b1000, 4);
    @(negedge clk);
    chk("sipo.par", 32'(sipo_q), 32'h6);

    // LSB-first instance
    @(negedge clk);
    l_valid = 1'b1;
    l_data  = 4'b0001;
    @(posedge clk);
    #1 l_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("lsb.so%0d", i), 32'(l_out), (i == 0) ? 1 : 0);
      chk($sformatf("lsb.sv%0d", i), 32'(l_sv), 1);
      chk($sformatf("lsb.fs%0d", i), 32'(l_fs), (i == 0) ? 1 : 0);
    end
    @(negedge clk);
    chk("lsb.end.sv", 32'(l_sv), 0);

    // Reset during bit 2 of F with 3 held
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'hF;
    @(posedge clk);
    #1 in_data = 4'h3;
    @(negedge clk);
    chk("abort.fs0", 32'(frame_start), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("abort.sv1", 32'(serial_valid), 1);
    chk("abort.rdy1", 32'(in_ready), 0);
    #2 rst = 1'b1;
    #1;
    chk_idle("abort.rst", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("abort.q%0d.sv", i), 32'(serial_valid), 0);
      chk($sformatf("abort.q%0d.busy", i), 32'(busy), 0);
      chk($sformatf("abort.q%0d.rdy", i), 32'(in_ready), 1);
    end

    // Fresh word after the abort still works
    send_one(4'b1001);
    chk_bits("post", 8'b1001, 8'b1000, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
